// File: rtl/udp_payload_unpack_pkg.sv
// Shared types for the UDP payload unpacker: FSM state encoding and the
// byte-keep mapping for the final word of a frame.
package udp_payload_unpack_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_READ  = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    // Low two bits of a byte count -> MSB-first keep for the word holding the last byte.
    function automatic logic [3:0] keep_from_len(input logic [1:0] len_lsb);
        logic [3:0] keep;
        case (len_lsb)
            2'd1:    keep = 4'b1000;
            2'd2:    keep = 4'b1100;
            2'd3:    keep = 4'b1110;
            default: keep = 4'b1111;
        endcase
        return keep;
    endfunction

endpackage

// File: rtl/udp_payload_unpack_byte_packer_32.sv
// Packs a byte stream big-endian into 32-bit words with a one-byte skid so an
// in-flight FIFO byte is never lost while the output word is stalled.
module byte_packer_32
    import udp_payload_unpack_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        in_vld,
    input  logic [7:0]  in_dat,
    input  logic        in_last,
    output logic [31:0] m_data,
    output logic [3:0]  m_keep,
    output logic        m_last,
    output logic        m_valid,
    input  logic        m_ready,
    output logic        stall
);

    logic [31:0] pack_q, pack_d;
    logic [2:0]  lane_q, lane_d;
    logic        vld_q, vld_d;
    logic        last_q, last_d;
    logic [3:0]  keep_q, keep_d;
    logic [7:0]  skid_q, skid_d;
    logic        skid_vld_q, skid_vld_d;
    logic        skid_last_q, skid_last_d;

    logic        accept;
    logic        take;
    logic [7:0]  byte_dat;
    logic        byte_last;

    always_comb begin
        pack_d      = pack_q;
        lane_d      = lane_q;
        vld_d       = vld_q;
        last_d      = last_q;
        keep_d      = keep_q;
        skid_d      = skid_q;
        skid_vld_d  = skid_vld_q;
        skid_last_d = skid_last_q;
        take        = 1'b0;
        byte_dat    = 8'h00;
        byte_last   = 1'b0;
        accept      = vld_q & m_ready;

        if (accept) begin
            pack_d = 32'h0;
            lane_d = 3'd0;
            vld_d  = 1'b0;
            last_d = 1'b0;
            keep_d = 4'h0;
        end

        // Skid and a fresh byte never coexist: rxen is withheld while either is pending.
        if (accept && skid_vld_q) begin
            take        = 1'b1;
            byte_dat    = skid_q;
            byte_last   = skid_last_q;
            skid_d      = 8'h00;
            skid_vld_d  = 1'b0;
            skid_last_d = 1'b0;
        end else if (in_vld) begin
            if (vld_q && !accept) begin
                skid_d      = in_dat;
                skid_vld_d  = 1'b1;
                skid_last_d = in_last;
            end else begin
                take      = 1'b1;
                byte_dat  = in_dat;
                byte_last = in_last;
            end
        end

        if (take) begin
            case (lane_d[1:0])
                2'd0:    pack_d[31:24] = byte_dat;
                2'd1:    pack_d[23:16] = byte_dat;
                2'd2:    pack_d[15:8]  = byte_dat;
                default: pack_d[7:0]   = byte_dat;
            endcase
            lane_d = lane_d + 3'd1;
            if (lane_d == 3'd4 || byte_last) begin
                vld_d  = 1'b1;
                last_d = byte_last;
                keep_d = byte_last ? keep_from_len(lane_d[1:0]) : 4'b1111;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pack_q      <= 32'h0;
            lane_q      <= 3'd0;
            vld_q       <= 1'b0;
            last_q      <= 1'b0;
            keep_q      <= 4'h0;
            skid_q      <= 8'h00;
            skid_vld_q  <= 1'b0;
            skid_last_q <= 1'b0;
        end else begin
            pack_q      <= pack_d;
            lane_q      <= lane_d;
            vld_q       <= vld_d;
            last_q      <= last_d;
            keep_q      <= keep_d;
            skid_q      <= skid_d;
            skid_vld_q  <= skid_vld_d;
            skid_last_q <= skid_last_d;
        end
    end

    assign m_data  = pack_q;
    assign m_keep  = keep_q;
    assign m_last  = last_q;
    assign m_valid = vld_q;
    assign stall   = (vld_q & ~m_ready) | skid_vld_q;

endmodule

// File: rtl/udp_payload_unpack.sv
// Filters received UDP frames by destination port, drains payload bytes from
// the receive cache FIFO and hands accepted payloads out as packed 32-bit words.
module udp_payload_unpack
    import udp_payload_unpack_pkg::*;
#(
    parameter logic [15:0] LOCAL_PORT = 16'h1F90,
    parameter int          MAX_LEN    = 1472,
    parameter int          CNT_W      = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             fs,
    output logic             fd,
    input  logic [15:0]      det_ip_port,
    input  logic [15:0]      data_len,
    output logic             fifo_rxen,
    input  logic [7:0]       fifo_rxd,
    output logic [31:0]      m_data,
    output logic [3:0]       m_keep,
    output logic             m_last,
    output logic             m_valid,
    input  logic             m_ready,
    output logic [CNT_W-1:0] drop_cnt
);

    localparam logic [15:0] MAX_LEN_W = 16'(MAX_LEN);

    state_t           state_q, state_d;
    logic [15:0]      rem_q, rem_d;
    logic [CNT_W-1:0] drop_q, drop_d;
    logic             rd_vld_q, rd_vld_d;
    logic             rd_last_q, rd_last_d;
    logic             drop_inc;
    logic             accept;
    logic             stall;

    assign accept = (det_ip_port == LOCAL_PORT) && (data_len != 16'd0) &&
                    (data_len <= MAX_LEN_W);

    always_comb begin
        state_d   = state_q;
        rem_d     = rem_q;
        drop_d    = drop_q;
        rd_vld_d  = 1'b0;
        rd_last_d = 1'b0;
        drop_inc  = 1'b0;
        fifo_rxen = 1'b0;
        fd        = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (fs) begin
                    rem_d = data_len;
                    if (data_len == 16'd0) begin
                        drop_inc = 1'b1;
                        state_d  = ST_DONE;
                    end else if (accept) begin
                        state_d = ST_READ;
                    end else begin
                        state_d = ST_DRAIN;
                    end
                end
            end
            ST_READ: begin
                if (rem_q != 16'd0 && !stall) begin
                    fifo_rxen = 1'b1;
                    rem_d     = rem_q - 16'd1;
                    rd_vld_d  = 1'b1;
                    rd_last_d = (rem_q == 16'd1);
                end
                if (m_valid && m_ready && m_last) begin
                    state_d = ST_DONE;
                end
            end
            ST_DRAIN: begin
                // The cycle after the final read lets the last byte leave the FIFO port.
                if (rem_q != 16'd0) begin
                    fifo_rxen = 1'b1;
                    rem_d     = rem_q - 16'd1;
                end else begin
                    drop_inc = 1'b1;
                    state_d  = ST_DONE;
                end
            end
            default: begin
                fd = 1'b1;
                if (!fs) begin
                    state_d = ST_IDLE;
                end
            end
        endcase

        if (drop_inc && drop_q != {CNT_W{1'b1}}) begin
            drop_d = drop_q + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            rem_q     <= 16'd0;
            drop_q    <= '0;
            rd_vld_q  <= 1'b0;
            rd_last_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            rem_q     <= rem_d;
            drop_q    <= drop_d;
            rd_vld_q  <= rd_vld_d;
            rd_last_q <= rd_last_d;
        end
    end

    assign drop_cnt = drop_q;

    byte_packer_32 u_packer (
        .clk     (clk),
        .rst     (rst),
        .in_vld  (rd_vld_q),
        .in_dat  (fifo_rxd),
        .in_last (rd_last_q),
        .m_data  (m_data),
        .m_keep  (m_keep),
        .m_last  (m_last),
        .m_valid (m_valid),
        .m_ready (m_ready),
        .stall   (stall)
    );

endmodule

// File: doc/udp_payload_unpack.md
Name: udp_payload_unpack

Overview:
- Sits directly downstream of the Ethernet receive top.
- Accepts a received UDP frame through the fs/fd handshake and filters it by destination port.
- Drains the payload bytes from the receive cache FIFO and packs them big-endian into 32-bit words for the application, with valid/ready, last and byte-keep.
- Frames addressed to other ports are drained from the FIFO and dropped, so the FIFO never retains stale bytes.

Parameters:
- LOCAL_PORT, 16'h1F90: accepted UDP destination port (8080).
- MAX_LEN, 1472: largest accepted payload length in bytes; longer frames are dropped.
- CNT_W, 16: width of the drop counter.

Ports:
- clk  input  1  system clock.
- rst  input  1  reset, asynchronous, active-high.
- fs  input  1  frame ready from receive top; level, held until fd is seen.
- fd  output  1  frame consumed; held high until fs falls.
- det_ip_port  input  16  destination port of current frame; stable while fs is high.
- data_len  input  16  payload length in bytes; stable while fs is high.
- fifo_rxen  output  1  cache FIFO read enable; data returns on fifo_rxd the following cycle.
- fifo_rxd  input  8  cache FIFO read data.
- m_data  output  32  packed payload word; first byte in [31:24].
- m_keep  output  4  valid byte lanes, MSB-first (4'b1000 = only [31:24] valid).
- m_last  output  1  final word of the frame.
- m_valid  output  1  word valid.
- m_ready  input  1  consumer accepts the word when m_valid and m_ready are both high.
- drop_cnt  output  CNT_W  count of dropped frames; saturates at all-ones.

Behaviour:
- Reset: all outputs 0; state IDLE; internal counters and the skid register cleared. Reset mid-frame abandons the frame; FIFO contents are not restored.
- State IDLE:
  - On fs=1, latch data_len into rem and evaluate accept.
  - accept = (det_ip_port==LOCAL_PORT) && (data_len!=0) && (data_len<=MAX_LEN).
  - Next state is READ if accept, else DRAIN. If data_len==0, go straight to DONE; the frame counts as dropped.
- State READ:
  - Assert fifo_rxen when rem!=0 and the output is not stalled. Stalled = m_valid && !m_ready.
  - Each rxen decrements rem.
  - The byte returning one cycle later is shifted into the packing register, lane order [31:24], [23:16], [15:8], [7:0].
- Skid register:
  - One byte deep. It captures a byte arriving while the packing register holds a complete, unaccepted word.
  - It is emptied into lane 0 of the next word on acceptance.
  - rxen is also withheld while the skid register is full.
- Word output:
  - A word is presented (m_valid=1) when 4 bytes are packed, or when the last byte has arrived.
  - On the final word, m_last=1 and m_keep reflects data_len[1:0]: 0 gives 4'b1111, 1 gives 4'b1000, 2 gives 4'b1100, 3 gives 4'b1110. Unused lanes are zero.
  - m_data, m_keep and m_last stay stable while m_valid && !m_ready.
- When the last word is accepted, go to DONE.
- State DRAIN:
  - Assert fifo_rxen every cycle while rem!=0, ignoring m_ready. m_valid stays 0.
  - Wait one extra cycle for the final byte, increment drop_cnt (saturating), then go to DONE.
- State DONE: drive fd=1; when fs=0, drop fd and return to IDLE. fs may already be low on entry; fd is still high for at least one cycle.
- Throughput: 1 byte/cycle with m_ready held high; one frame produces ceil(len/4) words.
- Latency: first rxen one cycle after fs is sampled; first word valid 5 cycles after fs sampled.
- fs re-asserting while in DONE before fd is seen low is ignored until IDLE.
- Width rule: rem is 16 bits and never underflows; rxen is never issued with rem==0.

Decomposition:
- Shared package: state encoding (IDLE, READ, DRAIN, DONE) and the keep-from-length mapping function.
- One natural sub-module: byte_packer_32. It contains the shift/pack register, lane counter, skid byte and valid/ready output stage.
- The parent keeps the FSM, filter, rem counter and drop counter.

Test Plan:
- Port 8080, len 8, bytes 01..08, m_ready=1 -> words 0x01020304 (keep F, last 0) then 0x05060708 (keep F, last 1); exactly 8 rxen pulses; fd high until fs drops.
- Port 8080, len 5, bytes AA..EE -> 0xAABBCCDD keep F, then 0xEE000000 keep 4'b1000 last 1.
- Port 9000, len 6 -> 6 rxen pulses, m_valid never high, drop_cnt 0 to 1, fd asserted.
- Port 8080, len 12, m_ready low for 5 cycles at first word -> no byte lost or duplicated; words 0x..., order preserved; rxen paused while stalled.
- len 0, then len 1473 on port 8080 -> no rxen for len 0; 1473 rxen with no output for len 1473; drop_cnt +2.
- Assert rst during READ after 3 bytes of len 8 -> all outputs 0 immediately; the next frame (len 4) packs correctly from lane [31:24].
